ex_alu_stage: RTL and testbench

Execute-stage block of the pipelined MIPS core. It captures the decode-stage bundle into the ID/EX register, including the 4-bit `ALUControlD` produced by the ALU decoder. It evaluates the ALU operation in EX and registers the result, flags and writeback control into the EX/MEM register for the memory stage. The block handles hazard-unit stall and flush, and exposes the combinational EX result for forwarding.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/alu_core.sv | 32 +++
 rtl/ex_alu_stage.sv | 123 ++++++++++++
 tb/tb_ex_alu_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU op codes (also used by the ALU decoder) and the ID/EX control bundle.
// The ovf_check field exists only when EX_OVF_TRAP_EN is defined.
package mips_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_LUI  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [4:0] write_reg;
    logic [3:0] alu_ctrl;
`ifdef EX_OVF_TRAP_EN
    logic       ovf_check;
`endif
  } idex_ctrl_t;

  localparam idex_ctrl_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/alu_core.sv
// Combinational MIPS ALU: result for the 4-bit op code plus an A==B flag for branches.
module alu_core
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] result_o,
  output logic             eq_o
);

  always_comb begin
    result_o = '0;
    unique case (op_i)
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_NOR:  result_o = ~(a_i | b_i);
      ALU_SUB:  result_o = a_i - b_i;
      ALU_LUI:  result_o = {b_i[15:0], {(WIDTH-16){1'b0}}};
      ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      default:  result_o = '0;
    endcase
  end

  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/ex_alu_stage.sv
// MIPS execute stage: ID/EX register, ALU, EX/MEM register with stall/flush handling.
// Define EX_OVF_TRAP_EN to add OvfCheckD/OverflowM signed-overflow trapping for add/sub.
module ex_alu_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic             ValidD,
  input  logic [3:0]       ALUControlD,
  input  logic [WIDTH-1:0] SrcAD,
  input  logic [WIDTH-1:0] SrcBD,
  input  logic             RegWriteD,
  input  logic [4:0]       WriteRegD,
`ifdef EX_OVF_TRAP_EN
  input  logic             OvfCheckD,
  output logic             OverflowM,
`endif
  output logic [WIDTH-1:0] ALUResultE,
  output logic [WIDTH-1:0] ALUResultM,
  output logic             ZeroM,
  output logic             RegWriteM,
  output logic [4:0]       WriteRegM,
  output logic             ValidM
);

  idex_ctrl_t       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] src_a_q, src_b_q;
  logic             eq_e;
  logic             issue_e;
  logic             trap_e;

  logic [WIDTH-1:0] result_m_q;
  logic             zero_m_q, reg_write_m_q, valid_m_q;
  logic [4:0]       write_reg_m_q;

  always_comb begin
    ctrl_d           = IDEX_BUBBLE;
    ctrl_d.valid     = ValidD;
    ctrl_d.reg_write = RegWriteD;
    ctrl_d.write_reg = WriteRegD;
    ctrl_d.alu_ctrl  = ALUControlD;
`ifdef EX_OVF_TRAP_EN
    ctrl_d.ovf_check = OvfCheckD;
`endif
  end

  // Flush outranks stall so a squashed instruction never lingers in EX.
  always_ff @(posedge clk) begin
    if (!rst_n || FlushE) begin
      ctrl_q  <= IDEX_BUBBLE;
      src_a_q <= '0;
      src_b_q <= '0;
    end else if (!StallE) begin
      ctrl_q  <= ctrl_d;
      src_a_q <= SrcAD;
      src_b_q <= SrcBD;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a_i      (src_a_q),
    .b_i      (src_b_q),
    .op_i     (ctrl_q.alu_ctrl),
    .result_o (ALUResultE),
    .eq_o     (eq_e)
  );

  // A held instruction reaches MEM only once, on the cycle the stall releases.
  assign issue_e = ctrl_q.valid && !StallE;

`ifdef EX_OVF_TRAP_EN
  logic ovf_e;
  logic overflow_m_q;

  always_comb begin
    ovf_e = 1'b0;
    if (ctrl_q.alu_ctrl == ALU_ADD)
      ovf_e = (src_a_q[WIDTH-1] == src_b_q[WIDTH-1]) &&
              (ALUResultE[WIDTH-1] != src_a_q[WIDTH-1]);
    else if (ctrl_q.alu_ctrl == ALU_SUB)
      ovf_e = (src_a_q[WIDTH-1] != src_b_q[WIDTH-1]) &&
              (ALUResultE[WIDTH-1] != src_a_q[WIDTH-1]);
  end

  assign trap_e = issue_e && ctrl_q.ovf_check && ovf_e;

  always_ff @(posedge clk) begin
    if (!rst_n) overflow_m_q <= 1'b0;
    else        overflow_m_q <= trap_e;
  end

  assign OverflowM = overflow_m_q;
`else
  assign trap_e = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_m_q    <= '0;
      zero_m_q      <= 1'b0;
      reg_write_m_q <= 1'b0;
      write_reg_m_q <= '0;
      valid_m_q     <= 1'b0;
    end else begin
      result_m_q    <= ALUResultE;
      zero_m_q      <= eq_e;
      reg_write_m_q <= issue_e && ctrl_q.reg_write && !trap_e;
      write_reg_m_q <= ctrl_q.write_reg;
      valid_m_q     <= issue_e;
    end
  end

  assign ALUResultM = result_m_q;
  assign ZeroM      = zero_m_q;
  assign RegWriteM  = reg_write_m_q;
  assign WriteRegM  = write_reg_m_q;
  assign ValidM     = valid_m_q;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Directed self-checking bench for ex_alu_stage; overflow steps build only with EX_OVF_TRAP_EN.
module tb_ex_alu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallE, FlushE, ValidD, RegWriteD;
  logic [3:0]  ALUControlD;
  logic [31:0] SrcAD, SrcBD;
  logic [4:0]  WriteRegD;
  logic [31:0] ALUResultE, ALUResultM;
  logic        ZeroM, RegWriteM, ValidM;
  logic [4:0]  WriteRegM;
`ifdef EX_OVF_TRAP_EN
  logic        OvfCheckD;
  logic        OverflowM;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  ex_alu_stage #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .StallE      (StallE),
    .FlushE      (FlushE),
    .ValidD      (ValidD),
    .ALUControlD (ALUControlD),
    .SrcAD       (SrcAD),
    .SrcBD       (SrcBD),
    .RegWriteD   (RegWriteD),
    .WriteRegD   (WriteRegD),
`ifdef EX_OVF_TRAP_EN
    .OvfCheckD   (OvfCheckD),
    .OverflowM   (OverflowM),
`endif
    .ALUResultE  (ALUResultE),
    .ALUResultM  (ALUResultM),
    .ZeroM       (ZeroM),
    .RegWriteM   (RegWriteM),
    .WriteRegM   (WriteRegM),
    .ValidM      (ValidM)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic rw, input logic [4:0] wr);
    ValidD = v; ALUControlD = op; SrcAD = a; SrcBD = b; RegWriteD = rw; WriteRegD = wr;
  endtask

  logic [31:0] sweep_exp [16];
  logic [31:0] b2b_a [4];
  logic [31:0] b2b_b [4];
  logic [3:0]  b2b_op [4];
  logic [31:0] b2b_exp [4];

  initial begin
    sweep_exp[0] = 32'h0000_0000;  sweep_exp[1] = 32'h8000_0001;
    sweep_exp[2] = 32'h8000_0001;  sweep_exp[3] = 32'h0000_0001;
    sweep_exp[4] = 32'h8000_0001;  sweep_exp[5] = 32'h7FFF_FFFE;
    sweep_exp[6] = 32'h7FFF_FFFF;  sweep_exp[7] = 32'h0001_0000;
    sweep_exp[8] = 32'h0000_0000;
    for (int i = 9; i < 16; i++) sweep_exp[i] = 32'h0;

    b2b_op[0] = 4'b0010; b2b_a[0] = 32'd1;    b2b_b[0] = 32'd2;    b2b_exp[0] = 32'd3;
    b2b_op[1] = 4'b0110; b2b_a[1] = 32'd10;   b2b_b[1] = 32'd3;    b2b_exp[1] = 32'd7;
    b2b_op[2] = 4'b0001; b2b_a[2] = 32'hF0;   b2b_b[2] = 32'h0F;   b2b_exp[2] = 32'hFF;
    b2b_op[3] = 4'b0000; b2b_a[3] = 32'hFF;   b2b_b[3] = 32'h0F;   b2b_exp[3] = 32'h0F;

    // Reset with random inputs
    rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
`ifdef EX_OVF_TRAP_EN
    OvfCheckD = 1'b1;
`endif
    drive(1'b1, 4'($urandom), $urandom, $urandom, 1'b1, 5'($urandom));
    tick();
    drive(1'b1, 4'($urandom), $urandom, $urandom, 1'b1, 5'($urandom));
    tick();
    check("rst_resultE", ALUResultE, 32'h0);
    check("rst_resultM", ALUResultM, 32'h0);
    check("rst_zeroM", {31'h0, ZeroM}, 32'h0);
    check("rst_regwriteM", {31'h0, RegWriteM}, 32'h0);
    check("rst_writeregM", {27'h0, WriteRegM}, 32'h0);
    check("rst_validM", {31'h0, ValidM}, 32'h0);
`ifdef EX_OVF_TRAP_EN
    check("rst_overflowM", {31'h0, OverflowM}, 32'h0);
    OvfCheckD = 1'b0;
`endif
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    tick();

    // Op sweep
    for (int op = 0; op < 16; op++) begin
      drive(1'b1, 4'(op), 32'h8000_0000, 32'h0000_0001, 1'b1, 5'(op));
      tick();
      drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0);
      tick();
      check($sformatf("sweep_op%0d", op), ALUResultM, sweep_exp[op]);
      if (op == 2) check("sweep_zeroM", {31'h0, ZeroM}, 32'h0);
    end

    drive(1'b1, 4'b0010, 32'd5, 32'd5, 1'b0, 5'd1);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    tick();
    check("eq_zeroM", {31'h0, ZeroM}, 32'h1);
    check("eq_resultM", ALUResultM, 32'd10);

    // Stall two cycles with add 3+4 in EX
    drive(1'b1, 4'b0010, 32'd3, 32'd4, 1'b1, 5'd7);
    tick();
    StallE = 1'b1;
    drive(1'b1, 4'b0110, 32'd100, 32'd1, 1'b1, 5'd9);
    tick();
    check("stall1_validM", {31'h0, ValidM}, 32'h0);
    check("stall1_regwriteM", {31'h0, RegWriteM}, 32'h0);
    check("stall1_resultE", ALUResultE, 32'd7);
    tick();
    check("stall2_validM", {31'h0, ValidM}, 32'h0);
    StallE = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    tick();
    check("stall_rel_validM", {31'h0, ValidM}, 32'h1);
    check("stall_rel_resultM", ALUResultM, 32'd7);
    check("stall_rel_regwriteM", {31'h0, RegWriteM}, 32'h1);
    check("stall_rel_writeregM", {27'h0, WriteRegM}, 32'd7);
    tick();
    check("stall_once_validM", {31'h0, ValidM}, 32'h0);

    // Flush together with stall
    drive(1'b1, 4'b0010, 32'd1, 32'd1, 1'b1, 5'd3);
    tick();
    FlushE = 1'b1; StallE = 1'b1;
    drive(1'b1, 4'b0001, 32'h55, 32'hAA, 1'b1, 5'd4);
    tick();
    check("flush_resultE", ALUResultE, 32'h0);
    FlushE = 1'b0; StallE = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    tick();
    check("flush_validM", {31'h0, ValidM}, 32'h0);
    check("flush_regwriteM", {31'h0, RegWriteM}, 32'h0);

    // Back-to-back issue
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1'b1, b2b_op[k], b2b_a[k], b2b_b[k], 1'b1, 5'(10 + k));
      else       drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0);
      tick();
      if (k >= 1) begin
        check($sformatf("b2b%0d_resultM", k - 1), ALUResultM, b2b_exp[k - 1]);
        check($sformatf("b2b%0d_writeregM", k - 1), {27'h0, WriteRegM}, 32'(10 + k - 1));
        check($sformatf("b2b%0d_validM", k - 1), {31'h0, ValidM}, 32'h1);
      end
    end
    tick();
    check("b2b_tail_validM", {31'h0, ValidM}, 32'h0);

    // Reset during a stall clears both registers
    drive(1'b1, 4'b0100, 32'hF0F0, 32'h0FF0, 1'b1, 5'd5);
    tick();
    StallE = 1'b1;
    rst_n = 1'b0;
    tick();
    check("midrst_resultE", ALUResultE, 32'h0);
    check("midrst_resultM", ALUResultM, 32'h0);
    check("midrst_validM", {31'h0, ValidM}, 32'h0);
    rst_n = 1'b1; StallE = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    tick();
    check("midrst_after_validM", {31'h0, ValidM}, 32'h0);

`ifdef EX_OVF_TRAP_EN
    OvfCheckD = 1'b1;
    drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd8);
    tick();
    OvfCheckD = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    tick();
    check("ovf_trap_overflowM", {31'h0, OverflowM}, 32'h1);
    check("ovf_trap_regwriteM", {31'h0, RegWriteM}, 32'h0);
    drive(1'b1, 4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd8);
    tick();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    tick();
    check("ovf_nochk_overflowM", {31'h0, OverflowM}, 32'h0);
    check("ovf_nochk_regwriteM", {31'h0, RegWriteM}, 32'h1);
    check("ovf_nochk_resultM", ALUResultM, 32'h8000_0000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
